// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB operand forwarding,
// ALU operand selection, control gating and load-use hazard detection.
`default_nettype none

module id_ex_stage (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_id_valid,
  input  logic [31:0] i_id_rs_data,
  input  logic [31:0] i_id_rt_data,
  input  logic [31:0] i_id_imm,
  input  logic [4:0]  i_id_shamt,
  input  logic [4:0]  i_id_rs,
  input  logic [4:0]  i_id_rt,
  input  logic        i_id_uses_rs,
  input  logic        i_id_uses_rt,
  input  logic [4:0]  i_id_wreg,
  input  logic [3:0]  i_id_aluc,
  input  logic        i_id_alusrc_imm,
  input  logic        i_id_shift,
  input  logic        i_id_regwrite,
  input  logic        i_id_memread,
  input  logic        i_id_memwrite,
  input  logic        i_id_memtoreg,
  input  logic        i_exmem_regwrite,
  input  logic [4:0]  i_exmem_wreg,
  input  logic [31:0] i_exmem_alu,
  input  logic        i_memwb_regwrite,
  input  logic [4:0]  i_memwb_wreg,
  input  logic [31:0] i_memwb_data,
  output logic [31:0] o_alu_r,
  output logic [31:0] o_alu_s,
  output logic [3:0]  o_alu_aluc,
  output logic [31:0] o_store_data,
  output logic        o_ex_valid,
  output logic [4:0]  o_ex_wreg,
  output logic        o_ex_regwrite,
  output logic        o_ex_memread,
  output logic        o_ex_memwrite,
  output logic        o_ex_memtoreg,
  output logic        o_load_use
);

  logic        valid;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] imm;
  logic [4:0]  shamt;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  wreg;
  logic [3:0]  aluc;
  logic        alusrc_imm;
  logic        shift;
  logic        regwrite;
  logic        memread;
  logic        memwrite;
  logic        memtoreg;

  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  // EX/MEM is the younger producer, so it takes priority over MEM/WB.
  always_comb begin
    fwd_rs = rs_data;
    if (i_exmem_regwrite && (i_exmem_wreg == rs) && (rs != 5'd0))
      fwd_rs = i_exmem_alu;
    else if (i_memwb_regwrite && (i_memwb_wreg == rs) && (rs != 5'd0))
      fwd_rs = i_memwb_data;
  end

  always_comb begin
    fwd_rt = rt_data;
    if (i_exmem_regwrite && (i_exmem_wreg == rt) && (rt != 5'd0))
      fwd_rt = i_exmem_alu;
    else if (i_memwb_regwrite && (i_memwb_wreg == rt) && (rt != 5'd0))
      fwd_rt = i_memwb_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst || i_flush) begin
      valid      <= 1'b0;
      rs_data    <= 32'd0;
      rt_data    <= 32'd0;
      imm        <= 32'd0;
      shamt      <= 5'd0;
      rs         <= 5'd0;
      rt         <= 5'd0;
      wreg       <= 5'd0;
      aluc       <= 4'd0;
      alusrc_imm <= 1'b0;
      shift      <= 1'b0;
      regwrite   <= 1'b0;
      memread    <= 1'b0;
      memwrite   <= 1'b0;
      memtoreg   <= 1'b0;
    end else if (i_stall) begin
      // Capture forwarded values so a held instruction survives its producer retiring.
      rs_data <= fwd_rs;
      rt_data <= fwd_rt;
    end else begin
      valid      <= i_id_valid;
      rs_data    <= i_id_rs_data;
      rt_data    <= i_id_rt_data;
      imm        <= i_id_imm;
      shamt      <= i_id_shamt;
      rs         <= i_id_rs;
      rt         <= i_id_rt;
      wreg       <= i_id_wreg;
      aluc       <= i_id_aluc;
      alusrc_imm <= i_id_alusrc_imm;
      shift      <= i_id_shift;
      regwrite   <= i_id_regwrite;
      memread    <= i_id_memread;
      memwrite   <= i_id_memwrite;
      memtoreg   <= i_id_memtoreg;
    end
  end

  assign o_alu_r       = shift ? {27'd0, shamt} : fwd_rs;
  assign o_alu_s       = alusrc_imm ? imm : fwd_rt;
  assign o_store_data  = fwd_rt;
  assign o_alu_aluc    = valid ? aluc : 4'd0;
  assign o_ex_valid    = valid;
  assign o_ex_wreg     = valid ? wreg : 5'd0;
  assign o_ex_regwrite = valid & regwrite;
  assign o_ex_memread  = valid & memread;
  assign o_ex_memwrite = valid & memwrite;
  assign o_ex_memtoreg = valid & memtoreg;

  assign o_load_use = i_id_valid & valid & memread & (wreg != 5'd0) &
                      ((i_id_uses_rs & (i_id_rs == wreg)) |
                       (i_id_uses_rt & (i_id_rt == wreg)));

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized stimulus against a
// behavioural model of the EX-stage contents.
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic        id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_shamt, id_rs, id_rt, id_wreg;
  logic        id_uses_rs, id_uses_rt;
  logic [3:0]  id_aluc;
  logic        id_alusrc, id_shift, id_regwrite, id_memread, id_memwrite, id_memtoreg;
  logic        exmem_regwrite = 1'b0, memwb_regwrite = 1'b0;
  logic [4:0]  exmem_wreg = 5'd0, memwb_wreg = 5'd0;
  logic [31:0] exmem_alu = 32'd0, memwb_data = 32'd0;

  logic [31:0] alu_r, alu_s, store_data;
  logic [3:0]  alu_aluc;
  logic        ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use;
  logic [4:0]  ex_wreg;

  int passed = 0;
  int total  = 0;

  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SLL = 4'h3;

  typedef struct packed {
    logic        valid;
    logic [31:0] rs_data, rt_data, imm;
    logic [4:0]  shamt, rs, rt, wreg;
    logic [3:0]  aluc;
    logic        alusrc, shift, regwrite, memread, memwrite, memtoreg;
  } ex_t;

  ex_t m;

  id_ex_stage dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush),
    .i_id_valid(id_valid), .i_id_rs_data(id_rs_data), .i_id_rt_data(id_rt_data),
    .i_id_imm(id_imm), .i_id_shamt(id_shamt), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(id_uses_rs), .i_id_uses_rt(id_uses_rt), .i_id_wreg(id_wreg),
    .i_id_aluc(id_aluc), .i_id_alusrc_imm(id_alusrc), .i_id_shift(id_shift),
    .i_id_regwrite(id_regwrite), .i_id_memread(id_memread),
    .i_id_memwrite(id_memwrite), .i_id_memtoreg(id_memtoreg),
    .i_exmem_regwrite(exmem_regwrite), .i_exmem_wreg(exmem_wreg), .i_exmem_alu(exmem_alu),
    .i_memwb_regwrite(memwb_regwrite), .i_memwb_wreg(memwb_wreg), .i_memwb_data(memwb_data),
    .o_alu_r(alu_r), .o_alu_s(alu_s), .o_alu_aluc(alu_aluc), .o_store_data(store_data),
    .o_ex_valid(ex_valid), .o_ex_wreg(ex_wreg), .o_ex_regwrite(ex_regwrite),
    .o_ex_memread(ex_memread), .o_ex_memwrite(ex_memwrite), .o_ex_memtoreg(ex_memtoreg),
    .o_load_use(load_use)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] stored);
    if (r == 5'd0) return stored;
    if (exmem_regwrite && exmem_wreg == r) return exmem_alu;
    if (memwb_regwrite && memwb_wreg == r) return memwb_data;
    return stored;
  endfunction

  task automatic clear_id();
    id_valid = 0; id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_wreg = 0; id_aluc = 0;
    id_alusrc = 0; id_shift = 0; id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    id_memtoreg = 0;
  endtask

  task automatic clear_fwd();
    exmem_regwrite = 0; exmem_wreg = 0; exmem_alu = 0;
    memwb_regwrite = 0; memwb_wreg = 0; memwb_data = 0;
  endtask

  // One clock edge; the model applies reset > flush > stall > load with the inputs
  // present just before the edge.
  task automatic step();
    ex_t nxt;
    if (rst || flush) nxt = '0;
    else if (stall) begin
      nxt = m;
      nxt.rs_data = fwd(m.rs, m.rs_data);
      nxt.rt_data = fwd(m.rt, m.rt_data);
    end else begin
      nxt.valid = id_valid; nxt.rs_data = id_rs_data; nxt.rt_data = id_rt_data;
      nxt.imm = id_imm; nxt.shamt = id_shamt; nxt.rs = id_rs; nxt.rt = id_rt;
      nxt.wreg = id_wreg; nxt.aluc = id_aluc; nxt.alusrc = id_alusrc; nxt.shift = id_shift;
      nxt.regwrite = id_regwrite; nxt.memread = id_memread; nxt.memwrite = id_memwrite;
      nxt.memtoreg = id_memtoreg;
    end
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic test_reset();
    clear_id(); clear_fwd();
    #2 rst = 1; m = '0;
    #1;
    total++; if (ex_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", ex_valid); else passed++;
    total++; if (ex_wreg !== 5'd0) $display("FAIL reset_wreg got=%h exp=0", ex_wreg); else passed++;
    total++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 4'b0)
      $display("FAIL reset_ctrl got=%b exp=0000", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}); else passed++;
    total++; if (alu_aluc !== 4'd0) $display("FAIL reset_aluc got=%h exp=0", alu_aluc); else passed++;
    total++; if (load_use !== 1'b0) $display("FAIL reset_load_use got=%b exp=0", load_use); else passed++;
    total++; if ({alu_r, alu_s, store_data} !== 96'd0)
      $display("FAIL reset_data got=%h/%h/%h exp=0", alu_r, alu_s, store_data); else passed++;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_load();
    clear_id();
    id_valid = 1; id_rs = 1; id_rt = 2; id_rs_data = 5; id_rt_data = 7; id_wreg = 3;
    id_aluc = ALU_ADD; id_regwrite = 1; id_uses_rs = 1; id_uses_rt = 1;
    step();
    total++; if (alu_r !== 32'd5) $display("FAIL load_alu_r got=%h exp=5", alu_r); else passed++;
    total++; if (alu_s !== 32'd7) $display("FAIL load_alu_s got=%h exp=7", alu_s); else passed++;
    total++; if (ex_wreg !== 5'd3) $display("FAIL load_wreg got=%h exp=3", ex_wreg); else passed++;
    total++; if (ex_regwrite !== 1'b1) $display("FAIL load_regwrite got=%b exp=1", ex_regwrite); else passed++;
    total++; if (alu_aluc !== ALU_ADD) $display("FAIL load_aluc got=%h exp=%h", alu_aluc, ALU_ADD); else passed++;
  endtask

  task automatic test_forward();
    clear_id();
    id_valid = 1; id_rs = 4; id_rs_data = 32'h1234; id_regwrite = 1; id_wreg = 8;
    step();
    exmem_regwrite = 1; exmem_wreg = 4; exmem_alu = 32'hAAAA0000;
    memwb_regwrite = 1; memwb_wreg = 4; memwb_data = 32'h11111111;
    #1;
    total++; if (alu_r !== 32'hAAAA0000) $display("FAIL fwd_exmem got=%h exp=aaaa0000", alu_r); else passed++;
    exmem_regwrite = 0;
    #1;
    total++; if (alu_r !== 32'h11111111) $display("FAIL fwd_memwb got=%h exp=11111111", alu_r); else passed++;
    clear_fwd();
    id_rs = 0; id_rs_data = 32'hCAFE;
    step();
    exmem_regwrite = 1; exmem_wreg = 0; exmem_alu = 32'hAAAA0000;
    memwb_regwrite = 1; memwb_wreg = 0; memwb_data = 32'h11111111;
    #1;
    total++; if (alu_r !== 32'hCAFE) $display("FAIL fwd_r0 got=%h exp=0000cafe", alu_r); else passed++;
    clear_fwd();
  endtask

  task automatic test_select();
    clear_id();
    id_valid = 1; id_shift = 1; id_shamt = 4; id_rt = 2; id_rt_data = 1; id_wreg = 3;
    id_aluc = ALU_SLL; id_regwrite = 1;
    step();
    total++; if (alu_r !== 32'd4) $display("FAIL sll_alu_r got=%h exp=4", alu_r); else passed++;
    total++; if (alu_s !== 32'd1) $display("FAIL sll_alu_s got=%h exp=1", alu_s); else passed++;
    clear_id();
    id_valid = 1; id_alusrc = 1; id_imm = 32'hFFFFFFFF; id_rs = 1; id_rt = 2; id_wreg = 2;
    step();
    total++; if (alu_s !== 32'hFFFFFFFF) $display("FAIL addi_alu_s got=%h exp=ffffffff", alu_s); else passed++;
    clear_id();
    id_valid = 1; id_alusrc = 1; id_imm = 8; id_rt = 9; id_rt_data = 0; id_memwrite = 1;
    step();
    memwb_regwrite = 1; memwb_wreg = 9; memwb_data = 32'h55;
    #1;
    total++; if (store_data !== 32'h55) $display("FAIL sw_store got=%h exp=55", store_data); else passed++;
    total++; if (alu_s !== 32'd8) $display("FAIL sw_alu_s got=%h exp=8", alu_s); else passed++;
    clear_fwd();
  endtask

  task automatic test_load_use();
    clear_id();
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_memtoreg = 1; id_wreg = 5; id_alusrc = 1;
    step();
    clear_id();
    id_valid = 1; id_rs = 1; id_rt = 5; id_uses_rt = 1;
    #1;
    total++; if (load_use !== 1'b1) $display("FAIL lu_rt got=%b exp=1", load_use); else passed++;
    id_uses_rt = 0;
    #1;
    total++; if (load_use !== 1'b0) $display("FAIL lu_unused got=%b exp=0", load_use); else passed++;
    id_rs = 5; id_uses_rs = 1;
    #1;
    total++; if (load_use !== 1'b1) $display("FAIL lu_rs got=%b exp=1", load_use); else passed++;
    id_valid = 0;
    #1;
    total++; if (load_use !== 1'b0) $display("FAIL lu_id_invalid got=%b exp=0", load_use); else passed++;
    clear_id();
    id_valid = 1; id_memread = 1; id_wreg = 0;
    step();
    clear_id();
    id_valid = 1; id_rt = 0; id_uses_rt = 1;
    #1;
    total++; if (load_use !== 1'b0) $display("FAIL lu_wreg0 got=%b exp=0", load_use); else passed++;
  endtask

  task automatic test_stall();
    clear_id();
    id_valid = 1; id_rs = 6; id_rs_data = 0; id_wreg = 7; id_regwrite = 1; id_aluc = ALU_ADD;
    step();
    clear_id();
    id_valid = 1; id_rs = 2; id_rs_data = 32'h999; id_wreg = 12;
    stall = 1; memwb_regwrite = 1; memwb_wreg = 6; memwb_data = 32'h77;
    #1;
    total++; if (alu_r !== 32'h77) $display("FAIL stall_c1_r got=%h exp=77", alu_r); else passed++;
    step();
    clear_fwd();
    #1;
    total++; if (alu_r !== 32'h77) $display("FAIL stall_c2_r got=%h exp=77", alu_r); else passed++;
    step();
    total++; if (alu_r !== 32'h77) $display("FAIL stall_after_r got=%h exp=77", alu_r); else passed++;
    total++; if (ex_wreg !== 5'd7) $display("FAIL stall_hold_wreg got=%h exp=7", ex_wreg); else passed++;
    stall = 0;
  endtask

  task automatic test_flush();
    clear_id();
    id_valid = 1; id_wreg = 7; id_aluc = 4'h3; id_regwrite = 1; id_memwrite = 1;
    step();
    flush = 1; stall = 1;
    step();
    total++; if (ex_valid !== 1'b0) $display("FAIL flush_valid got=%b exp=0", ex_valid); else passed++;
    total++; if ({ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg} !== 4'b0)
      $display("FAIL flush_ctrl got=%b exp=0000", {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg}); else passed++;
    total++; if (alu_aluc !== 4'd0) $display("FAIL flush_aluc got=%h exp=0", alu_aluc); else passed++;
    flush = 0; stall = 0;
    step();
    total++; if (ex_wreg !== 5'd7) $display("FAIL reload_wreg got=%h exp=7", ex_wreg); else passed++;
    clear_id();
    stall = 1;
    step();
    total++; if (ex_valid !== 1'b1) $display("FAIL hold_valid got=%b exp=1", ex_valid); else passed++;
    total++; if (alu_aluc !== 4'h3) $display("FAIL hold_aluc got=%h exp=3", alu_aluc); else passed++;
    rst = 1; m = '0;
    #1;
    total++; if (ex_valid !== 1'b0) $display("FAIL rst_mid_stall got=%b exp=0", ex_valid); else passed++;
    rst = 0; stall = 0;
    id_valid = 1; id_wreg = 9; id_regwrite = 1;
    step();
    total++; if (ex_wreg !== 5'd9) $display("FAIL rst_then_load got=%h exp=9", ex_wreg); else passed++;
  endtask

  task automatic test_random();
    logic [110:0] got, exp;
    logic [31:0]  fr, ft;
    logic         lu;
    for (int i = 0; i < 300; i++) begin
      id_valid = 1'($urandom_range(0, 3) != 0);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_shamt = 5'($urandom); id_rs = 5'($urandom_range(0, 3)); id_rt = 5'($urandom_range(0, 3));
      id_uses_rs = 1'($urandom); id_uses_rt = 1'($urandom); id_wreg = 5'($urandom_range(0, 3));
      id_aluc = 4'($urandom); id_alusrc = 1'($urandom); id_shift = 1'($urandom);
      id_regwrite = 1'($urandom); id_memread = 1'($urandom);
      id_memwrite = 1'($urandom); id_memtoreg = 1'($urandom);
      exmem_regwrite = 1'($urandom); exmem_wreg = 5'($urandom_range(0, 3)); exmem_alu = $urandom;
      memwb_regwrite = 1'($urandom); memwb_wreg = 5'($urandom_range(0, 3)); memwb_data = $urandom;
      stall = 1'($urandom_range(0, 4) == 0);
      flush = 1'($urandom_range(0, 7) == 0);
      #1;
      fr = fwd(m.rs, m.rs_data);
      ft = fwd(m.rt, m.rt_data);
      lu = id_valid && m.valid && m.memread && (m.wreg != 0) &&
           ((id_uses_rs && id_rs == m.wreg) || (id_uses_rt && id_rt == m.wreg));
      exp = {m.shift ? {27'd0, m.shamt} : fr, m.alusrc ? m.imm : ft, ft,
             m.valid ? m.aluc : 4'd0, m.valid, m.valid ? m.wreg : 5'd0,
             m.valid & m.regwrite, m.valid & m.memread, m.valid & m.memwrite,
             m.valid & m.memtoreg, lu};
      got = {alu_r, alu_s, store_data, alu_aluc, ex_valid, ex_wreg,
             ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use};
      total++; if (got !== exp) $display("FAIL random_%0d got=%h exp=%h", i, got, exp); else passed++;
      step();
    end
    stall = 0; flush = 0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_forward();
    test_select();
    test_load_use();
    test_stall();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
